// File: rtl/int_div_preproc_pipe.sv
// int_div_preproc_pipe: two-stage integer divide preprocessor producing normalised iterator operands.
module int_div_preproc_pipe #(
  parameter int XLEN = 64,
  parameter int DIVB = 64,
  parameter int RK   = 2,
  parameter int LOGR = 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              flush,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [XLEN-1:0]                   SrcA,
  input  logic [XLEN-1:0]                   SrcB,
  input  logic [2:0]                        Funct3,
  input  logic                              W64,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [DIVB+3:0]                   X,
  output logic [DIVB+3:0]                   D,
  output logic [$clog2(DIVB/RK+2)-1:0]      Cycles,
  output logic [$clog2(DIVB+1)-1:0]         NormShift,
  output logic                              Special,
  output logic                              BZero,
  output logic                              ALTB,
  output logic                              SOvf,
  output logic                              As,
  output logic                              Bs,
  output logic                              RemOp,
  output logic                              W64Out,
  output logic [XLEN-1:0]                   AOut
);
  localparam int NW = DIVB + 1;
  localparam int LW = $clog2(DIVB + 2);
  localparam int ZW = LW + 1;
  localparam int CW = $clog2(DIVB / RK + 2);
  localparam int SW = $clog2(DIVB + 1);
  logic s1_valid, s2_take, accept, sgn, w_op, a_s, b_s, unused_f3;
  logic [XLEN-1:0] a_adj, b_adj, mneg;
  logic s1_as, s1_bs, s1_azero, s1_bzero, s1_sovf, s1_rem, s1_w64;
  logic [XLEN-1:0] s1_a, s1_pa, s1_pb;
  logic [NW-1:0] ifx, ifd, xn, dn;
  logic [LW-1:0] ell, m;
  logic [ZW-1:0] zdiff, p;
  logic altb_c, special_c;
  int bits, sh, cyc, ns;
  assign s2_take   = ~out_valid | out_ready;
  assign in_ready  = ~s1_valid | s2_take;
  assign accept    = in_valid & in_ready;
  assign sgn       = ~Funct3[0];
  assign unused_f3 = Funct3[2];
  if (XLEN > 32) begin : g_wide
    assign w_op  = W64;
    assign a_adj = W64 ? {{(XLEN-32){sgn & SrcA[31]}}, SrcA[31:0]} : SrcA;
    assign b_adj = W64 ? {{(XLEN-32){sgn & SrcB[31]}}, SrcB[31:0]} : SrcB;
  end else begin : g_narrow
    logic unused_w64;
    assign unused_w64 = W64;
    assign w_op  = 1'b0;
    assign a_adj = SrcA;
    assign b_adj = SrcB;
  end
  // Word ops compare against the sign-extended 32-bit minimum.
  assign mneg = w_op ? {XLEN{1'b1}} << 31 : {XLEN{1'b1}} << (XLEN - 1);
  assign a_s  = sgn & a_adj[XLEN-1];
  assign b_s  = sgn & b_adj[XLEN-1];
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      {s1_a, s1_pa, s1_pb, s1_as, s1_bs, s1_azero, s1_bzero, s1_sovf, s1_rem, s1_w64} <= '0;
    end else begin
      if (flush) s1_valid <= 1'b0;
      else if (in_ready) s1_valid <= in_valid;
      if (accept) begin
        s1_a     <= a_adj;
        s1_pa    <= a_s ? -a_adj : a_adj;
        s1_pb    <= b_s ? -b_adj : b_adj;
        s1_as    <= a_s;
        s1_bs    <= b_s;
        s1_azero <= a_adj == '0;
        s1_bzero <= b_adj == '0;
        s1_sovf  <= sgn & (a_adj == mneg) & (&b_adj);
        s1_rem   <= Funct3[1];
        s1_w64   <= w_op;
      end
    end
  end
  function automatic logic [LW-1:0] lzc(input logic [NW-1:0] v);
    lzc = LW'(NW);
    for (int i = 0; i < NW; i++) if (v[i]) lzc = LW'(NW - 1 - i);
  endfunction
  assign ifx = {s1_pa, {(NW-XLEN){1'b0}}};
  assign ifd = {s1_pb, {(NW-XLEN){1'b0}}};
  always_comb begin
    ell       = lzc(ifx);
    m         = lzc(ifd);
    xn        = ifx << ell;
    dn        = ifd << m;
    zdiff     = {1'b0, m} - {1'b0, ell};
    altb_c    = zdiff[ZW-1] | (s1_azero & ~s1_bzero);
    special_c = s1_bzero | altb_c | s1_sovf;
    p         = altb_c ? '0 : zdiff;
    bits      = LOGR + int'(p);
    cyc       = special_c ? 0 : (bits + RK - 1) / RK;
    sh        = RK - 1 - (bits - 1) % RK;
    ns        = s1_rem ? int'(m) + DIVB - (XLEN - 1) : DIVB - (cyc * RK - LOGR);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      {X, D, Cycles, NormShift, Special, BZero, ALTB, SOvf, As, Bs, RemOp, W64Out, AOut} <= '0;
    end else begin
      if (flush) out_valid <= 1'b0;
      else if (s2_take) out_valid <= s1_valid;
      if (s2_take) begin
        X         <= {3'b000, xn} >> sh;
        D         <= {3'b000, dn};
        Cycles    <= CW'(cyc);
        NormShift <= SW'(ns);
        Special   <= special_c;
        BZero     <= s1_bzero;
        ALTB      <= altb_c;
        SOvf      <= s1_sovf;
        As        <= s1_as;
        Bs        <= s1_bs;
        RemOp     <= s1_rem;
        W64Out    <= s1_w64;
        AOut      <= s1_a;
      end
    end
  end
endmodule

// File: tb/tb_int_div_preproc_pipe.sv
// tb_int_div_preproc_pipe: table and scoreboard bench for the divide preprocessor (32- and 64-bit builds).
module tb_int_div_preproc_pipe;
  typedef struct packed {
    logic [35:0] x, d;
    logic [4:0]  cyc;
    logic [5:0]  ns;
    logic        special, bzero, altb, sovf, asg, bsg, rem;
    logic [31:0] aout;
  } res_t;
  typedef struct {
    logic [31:0] a, b;
    logic [2:0]  fn;
    res_t        e;
  } vec_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset, flush, in_valid, in_ready, out_valid, out_ready, w64;
  logic [31:0] src_a, src_b, aout;
  logic [2:0] f3;
  logic [35:0] x, d;
  logic [4:0] cycles;
  logic [5:0] nshift;
  logic special, bzero, altb, sovf, as_o, bs_o, rem_op, w64_out;
  logic v_in_valid, v_in_ready, v_out_valid, v_out_ready, v_w64;
  logic [63:0] v_a, v_b, v_aout;
  logic [2:0] v_f3;
  logic [67:0] v_x, v_d;
  logic [5:0] v_cycles;
  logic [6:0] v_ns;
  logic v_special, v_bzero, v_altb, v_sovf, v_as, v_bs, v_rem, v_w64_out;
  int_div_preproc_pipe #(.XLEN(32), .DIVB(32), .RK(2), .LOGR(1)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .SrcA(src_a), .SrcB(src_b), .Funct3(f3), .W64(w64), .out_valid(out_valid), .out_ready(out_ready),
    .X(x), .D(d), .Cycles(cycles), .NormShift(nshift), .Special(special), .BZero(bzero),
    .ALTB(altb), .SOvf(sovf), .As(as_o), .Bs(bs_o), .RemOp(rem_op), .W64Out(w64_out), .AOut(aout)
  );
  int_div_preproc_pipe #(.XLEN(64), .DIVB(64), .RK(2), .LOGR(1)) dut64 (
    .clk(clk), .reset(reset), .flush(1'b0), .in_valid(v_in_valid), .in_ready(v_in_ready),
    .SrcA(v_a), .SrcB(v_b), .Funct3(v_f3), .W64(v_w64), .out_valid(v_out_valid), .out_ready(v_out_ready),
    .X(v_x), .D(v_d), .Cycles(v_cycles), .NormShift(v_ns), .Special(v_special), .BZero(v_bzero),
    .ALTB(v_altb), .SOvf(v_sovf), .As(v_as), .Bs(v_bs), .RemOp(v_rem), .W64Out(v_w64_out), .AOut(v_aout)
  );
  int checks = 0, failures = 0, n_out = 0, n_sent = 0, cyc_n = 0, last_acc = 0;
  bit rand_rdy = 0;
  res_t sb[$];
  vec_t tv[8];
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s act=%h req=%h", name, act, req);
    end
  endtask
  function automatic res_t cur();
    return {x, d, cycles, nshift, special, bzero, altb, sovf, as_o, bs_o, rem_op, aout};
  endfunction
  function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] fn);
    res_t r;
    logic [31:0] pa, pb;
    logic [63:0] xv, dv;
    int ell, m, bits, cyc;
    logic sg;
    r = '0;
    sg = !fn[0];
    r.asg = sg & a[31];
    r.bsg = sg & b[31];
    pa = r.asg ? -a : a;
    pb = r.bsg ? -b : b;
    ell = 33;
    m = 33;
    for (int i = 0; i < 32; i++) begin
      if (pa[i]) ell = 31 - i;
      if (pb[i]) m = 31 - i;
    end
    r.bzero = b == 0;
    r.sovf = sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
    r.altb = m < ell;
    r.special = r.bzero | r.altb | r.sovf;
    bits = r.altb ? 1 : 1 + m - ell;
    cyc = r.special ? 0 : (bits + 1) / 2;
    r.cyc = 5'(cyc);
    xv = {31'b0, pa, 1'b0} << ell;
    if (bits % 2 == 1) xv = xv >> 1;
    dv = {31'b0, pb, 1'b0} << m;
    r.x = xv[35:0];
    r.d = dv[35:0];
    r.ns = 6'(fn[1] ? m + 1 : 33 - 2 * cyc);
    r.rem = fn[1];
    r.aout = a;
    return r;
  endfunction
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [2:0] fn, input res_t e);
    int t;
    src_a = a;
    src_b = b;
    f3 = fn;
    in_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("send_ready", in_ready, 1);
    if (!in_ready) begin
      in_valid = 1'b0;
      return;
    end
    sb.push_back(e);
    n_sent++;
    @(posedge clk);
    #1;
    last_acc = cyc_n;
    in_valid = 1'b0;
  endtask
  always @(posedge clk) cyc_n++;
  initial forever begin
    @(posedge clk);
    #1;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  end
  res_t act, prev, exp_r;
  bit stalled = 0;
  always @(negedge clk) begin
    act = cur();
    if (stalled && out_valid) chk("stall_hold", act, prev);
    stalled = out_valid && !out_ready;
    prev = act;
    if (out_valid && out_ready) begin
      n_out++;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out act=%h req=none", act);
      end else begin
        exp_r = sb.pop_front();
        chk("result", act, exp_r);
      end
    end
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog act=running req=finished");
    $fatal(1);
  end
  initial begin
    int t, base, first;
    logic [31:0] ra, rb;
    logic [2:0] rf;
    tv[0] = '{32'd100, 32'd7, 3'b101, '{36'h0C8000000, 36'h1C0000000, 5'd3, 6'd27, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd100}};
    tv[1] = '{32'h80000000, 32'hFFFFFFFF, 3'b100, '{36'h100000000, 36'h100000000, 5'd0, 6'd33, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h80000000}};
    tv[2] = '{32'd5, 32'd0, 3'b101, '{36'h0A0000000, 36'h0, 5'd0, 6'd33, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd5}};
    tv[3] = '{32'd3, 32'd10, 3'b101, '{36'h0C0000000, 36'h140000000, 5'd0, 6'd33, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd3}};
    tv[4] = '{32'd100, 32'd7, 3'b111, '{36'h0C8000000, 36'h1C0000000, 5'd3, 6'd30, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd100}};
    tv[5] = '{32'hFFFFFF9C, 32'd7, 3'b100, '{36'h0C8000000, 36'h1C0000000, 5'd3, 6'd27, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFFFF9C}};
    tv[6] = '{32'd0, 32'd5, 3'b101, '{36'h0, 36'h140000000, 5'd0, 6'd33, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0}};
    tv[7] = '{32'hFFFFFFFF, 32'd1, 3'b101, '{36'h1FFFFFFFE, 36'h100000000, 5'd16, 6'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFF}};
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; w64 = 1'b0;
    src_a = '0; src_b = '0; f3 = 3'b101;
    v_in_valid = 1'b0; v_out_ready = 1'b1; v_w64 = 1'b1; v_a = '0; v_b = '0; v_f3 = 3'b100;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_data", {x, d, aout, cycles, nshift}, 0);
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      send(tv[i].a, tv[i].b, tv[i].fn, tv[i].e);
      @(negedge clk);
      chk("latency_c1", out_valid, 0);
      @(negedge clk);
      chk("latency_c2", out_valid, 1);
      @(posedge clk); #1;
    end
    first = 0;
    for (int i = 0; i < 4; i++) begin
      send(tv[i].a, tv[i].b, tv[i].fn, tv[i].e);
      if (i == 0) first = last_acc;
    end
    chk("throughput", last_acc - first, 3);
    rand_rdy = 1'b1;
    for (int i = 0; i < 24; i++) begin
      ra = $urandom >> $urandom_range(0, 31);
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom >> $urandom_range(0, 31);
      if (i % 6 == 5) begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
      rf = {1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))};
      send(ra, rb, rf, model(ra, rb, rf));
    end
    t = 0;
    while (sb.size() != 0 && t < 500) begin
      @(posedge clk);
      t++;
    end
    chk("drain_empty", sb.size(), 0);
    rand_rdy = 1'b0;
    @(posedge clk); #1 out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk("out_count", n_out, n_sent);
    out_ready = 1'b0;
    send(tv[0].a, tv[0].b, tv[0].fn, tv[0].e);
    send(tv[7].a, tv[7].b, tv[7].fn, tv[7].e);
    src_a = 32'd9; src_b = 32'd2; in_valid = 1'b1; flush = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("flush_pre_full", {out_valid, in_ready}, 2'b10);
    @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("flush_out_valid", out_valid, 0);
    base = n_out;
    repeat (6) @(negedge clk);
    @(posedge clk); #1;
    chk("flush_no_stale", n_out - base, 0);
    in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("flush_beats_accept", out_valid, 0);
    @(posedge clk); #1 out_ready = 1'b0;
    send(tv[5].a, tv[5].b, tv[5].fn, tv[5].e);
    send(tv[1].a, tv[1].b, tv[1].fn, tv[1].e);
    src_a = 32'd9; src_b = 32'd2; in_valid = 1'b1; flush = 1'b1; reset = 1'b1;
    sb.delete();
    @(posedge clk); #1 reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("reset_mid_out_valid", out_valid, 0);
    chk("reset_mid_in_ready", in_ready, 1);
    chk("reset_mid_x", x, 0);
    base = n_out;
    repeat (6) @(negedge clk);
    @(posedge clk); #1;
    chk("reset_no_stale", n_out - base, 0);
    v_a = 64'h00000000_FFFFFFFF; v_b = 64'd3; v_f3 = 3'b100; v_w64 = 1'b1; v_in_valid = 1'b1;
    @(posedge clk); #1 v_in_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("w64_signed", {v_out_valid, v_as, v_w64_out, v_aout}, {3'b111, 64'hFFFFFFFF_FFFFFFFF});
    @(posedge clk); #1;
    v_f3 = 3'b101; v_in_valid = 1'b1;
    @(posedge clk); #1 v_in_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("w64_unsigned", {v_out_valid, v_as, v_w64_out, v_aout}, {3'b101, 64'h00000000_FFFFFFFF});
    @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
